// File: rtl/bw_io_hstl_chain_ctl_pkg.sv
// Shared types and constants for the HSTL
// edge-logic scan chain sequencer.
package bw_io_hstl_pkg;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_ISO   = 5'b00010,
    ST_CAP   = 5'b00100,
    ST_SHIFT = 5'b01000,
    ST_REL   = 5'b10000
  } state_e;

  // mselect=0: pads follow ckd, not the scan flops
  localparam logic [1:0] OBSEL_ISO = 2'b10;

  localparam int BITS_PER_CELL = 3;

endpackage

// File: rtl/bw_io_hstl_chain_ctl_if.sv
// Host-side req/ack bundle of the chain
// sequencer.
interface bw_io_hstl_chain_ctl_if #(
  parameter int CHAIN_LEN = 12
);

  logic                 req;
  logic                 req_cap;
  logic [CHAIN_LEN-1:0] wr_data;
  logic [CHAIN_LEN-1:0] rd_data;
  logic                 ack;
  logic                 busy;

  modport master (
    output req,
    output req_cap,
    output wr_data,
    input  rd_data,
    input  ack,
    input  busy
  );

  modport slave (
    input  req,
    input  req_cap,
    input  wr_data,
    output rd_data,
    output ack,
    output busy
  );

endinterface

// File: rtl/bw_io_hstl_chain_sreg.sv
// Pattern shift register (parallel load,
// serial out) plus unload capture register.
module bw_io_hstl_chain_sreg #(
  parameter int CHAIN_LEN = 12,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 reset_l,
  input  logic                 load_i,
  input  logic                 shift_i,
  input  logic [CHAIN_LEN-1:0] load_data_i,
  input  logic                 sin_i,
  input  logic [CNT_W-1:0]     idx_i,
  output logic                 head_d_o,
  output logic [CHAIN_LEN-1:0] cap_data_o
);

  logic [CHAIN_LEN-1:0] sreg_q;
  logic [CHAIN_LEN-1:0] sreg_d;
  logic [CHAIN_LEN-1:0] cap_q;
  logic [CHAIN_LEN-1:0] cap_d;

  always_comb begin
    sreg_d = sreg_q;
    if (load_i) begin
      sreg_d = load_data_i;
    end else if (shift_i) begin
      sreg_d = {1'b0, sreg_q[CHAIN_LEN-1:1]};
    end
  end

  // unload bits land in place, indexed by shift count
  always_comb begin
    cap_d = cap_q;
    for (int i = 0; i < CHAIN_LEN; i++) begin
      if (shift_i && (idx_i == CNT_W'(i))) begin
        cap_d[i] = sin_i;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      sreg_q <= '0;
      cap_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cap_q  <= cap_d;
    end
  end

  // si is registered, so it is fed from the next lsb
  assign head_d_o   = sreg_d[0];
  assign cap_data_o = cap_q;

endmodule

// File: rtl/bw_io_hstl_chain_ctl.sv
// Scan chain sequencer for a group of HSTL
// edge-logic cells: load pattern, unload old.
module bw_io_hstl_chain_ctl
  import bw_io_hstl_pkg::*;
#(
  parameter int NCELL     = 4,
  parameter int CHAIN_LEN = BITS_PER_CELL * NCELL,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic       clk,
  input  logic       reset_l,
  bw_io_hstl_chain_ctl_if.slave host,
  input  logic [1:0] func_obsel,
  output logic [1:0] obsel,
  input  logic       test_se,
  input  logic       test_si,
  output logic       se,
  output logic       si,
  input  logic       so
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(CHAIN_LEN - 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             capf_q;
  logic             capf_d;

  logic se_q;
  logic se_d;
  logic si_q;
  logic si_d;
  logic ack_q;
  logic ack_d;
  logic busy_q;
  logic busy_d;
  logic iso_q;
  logic iso_d;

  logic accept;
  logic shift_en;
  logic head_d;

  assign accept = (state_q == ST_IDLE)
                & host.req & ~test_se;

  assign shift_en = (state_q == ST_SHIFT)
                  & ~test_se;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      capf_q  <= 1'b0;
      se_q    <= 1'b0;
      si_q    <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      iso_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      capf_q  <= capf_d;
      se_q    <= se_d;
      si_q    <= si_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      iso_q   <= iso_d;
    end
  end

  // global scan enable aborts any operation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capf_d  = capf_q;
    if (test_se) begin
      state_d = ST_IDLE;
    end else begin
      unique case (1'b1)
        (state_q == ST_IDLE): begin
          if (host.req) begin
            state_d = ST_ISO;
            cnt_d   = '0;
            capf_d  = host.req_cap;
          end
        end
        (state_q == ST_ISO): begin
          state_d = capf_q ? ST_CAP : ST_SHIFT;
        end
        (state_q == ST_CAP): begin
          state_d = ST_SHIFT;
        end
        (state_q == ST_SHIFT): begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_REL;
          end
        end
        (state_q == ST_REL): begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // outputs registered from next state
  always_comb begin
    se_d   = (state_d == ST_SHIFT);
    si_d   = se_d & head_d;
    ack_d  = (state_d == ST_REL);
    busy_d = (state_d != ST_IDLE);
    iso_d  = (state_d != ST_IDLE);
  end

  bw_io_hstl_chain_sreg #(
    .CHAIN_LEN (CHAIN_LEN),
    .CNT_W     (CNT_W)
  ) u_sreg (
    .clk         (clk),
    .reset_l     (reset_l),
    .load_i      (accept),
    .shift_i     (shift_en),
    .load_data_i (host.wr_data),
    .sin_i       (so),
    .idx_i       (cnt_q),
    .head_d_o    (head_d),
    .cap_data_o  (host.rd_data)
  );

  assign host.ack  = ack_q;
  assign host.busy = busy_q;

  assign se    = test_se | se_q;
  assign si    = test_se ? test_si : si_q;
  assign obsel = (iso_q & ~test_se) ? OBSEL_ISO
                                     : func_obsel;

endmodule

// File: tb/tb_bw_io_hstl_chain_ctl.sv
// Scoreboard bench for bw_io_hstl_chain_ctl
// against a 4-cell behavioural chain model.
module tb_bw_io_hstl_chain_ctl;
  import bw_io_hstl_pkg::*;

  localparam int N = 12;

  logic       clk = 1'b0;
  logic       reset_l;
  logic [1:0] func_obsel;
  logic [1:0] obsel;
  logic       test_se;
  logic       test_si;
  logic       se;
  logic       si;
  logic       so;

  always #5 clk = ~clk;

  bw_io_hstl_chain_ctl_if #(.CHAIN_LEN(N)) hif();

  bw_io_hstl_chain_ctl #(.NCELL(4)) dut (
    .clk        (clk),
    .reset_l    (reset_l),
    .host       (hif),
    .func_obsel (func_obsel),
    .obsel      (obsel),
    .test_se    (test_se),
    .test_si    (test_si),
    .se         (se),
    .si         (si),
    .so         (so)
  );

  // m[N-1] = up flop of cell 0, m[0] = bypass of last cell
  logic [N-1:0] m;
  logic [N-1:0] live;
  logic [N-1:0] pre_val;
  logic         pre_en;
  logic         cells_cap;

  always @(posedge clk) begin
    if (pre_en) m <= pre_val;
    else if (se) m <= {si, m[N-1:1]};
    else if (cells_cap) m <= live;
  end

  assign so = m[0];

  typedef struct {
    logic [N-1:0] rd;
    logic [N-1:0] chain;
    int           lat;
    int           nse;
    int           gap;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [N-1:0] rd,
                          input logic [N-1:0] ch,
                          input int lat,
                          input int nse,
                          input int gap);
    exp_t e;
    e.rd = rd; e.chain = ch; e.lat = lat;
    e.nse = nse; e.gap = gap;
    q.push_back(e);
  endtask

  // monitor: per-cycle isolation check, pop on ack
  initial begin
    int   cyc = 0;
    int   start = 0;
    int   last_ack = -100;
    int   gap = 0;
    int   nse = 0;
    bit   seen_se = 1'b0;
    bit   pb = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      chk("obsel", 32'(obsel),
          32'((hif.busy && !test_se) ?
              OBSEL_ISO : func_obsel));
      if (hif.busy && !pb) begin
        start   = cyc;
        gap     = cyc - last_ack;
        nse     = 0;
        seen_se = 1'b0;
      end
      if (hif.busy && !seen_se) begin
        if (se) seen_se = 1'b1;
        else nse++;
      end
      if (hif.ack) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_ack: got 1 want 0");
        end else begin
          e = q.pop_front();
          chk("rd_data", 32'(hif.rd_data), 32'(e.rd));
          chk("chain", 32'(m), 32'(e.chain));
          chk("latency", 32'(cyc - start + 1),
              32'(e.lat));
          chk("se_low_lead", 32'(nse), 32'(e.nse));
          if (e.gap >= 0)
            chk("b2b_gap", 32'(gap), 32'(e.gap));
        end
        last_ack = cyc;
      end
      pb = hif.busy;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic preload(input logic [N-1:0] v);
    pre_val = v;
    pre_en  = 1'b1;
    @(negedge clk);
    pre_en  = 1'b0;
  endtask

  task automatic start(input logic [N-1:0] wr,
                       input logic cap);
    hif.wr_data = wr;
    hif.req_cap = cap;
    hif.req     = 1'b1;
    @(negedge clk);
    hif.req     = 1'b0;
  endtask

  task automatic wait_ack(input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      #2;
      k++;
    end while (!hif.ack && k < budget);
    if (!hif.ack) begin
      n_tests++;
      n_fail++;
      $display("FAIL ack_timeout: got 0 want 1");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset_l     = 1'b0;
    hif.req     = 1'b0;
    hif.req_cap = 1'b0;
    hif.wr_data = '0;
    func_obsel  = 2'b01;
    test_se     = 1'b0;
    test_si     = 1'b0;
    cells_cap   = 1'b0;
    live        = '0;
    pre_val     = '0;
    pre_en      = 1'b0;
    tick(2);
    #1;
    chk("rst_se", 32'(se), 32'(0));
    chk("rst_si", 32'(si), 32'(0));
    chk("rst_ack", 32'(hif.ack), 32'(0));
    chk("rst_busy", 32'(hif.busy), 32'(0));
    chk("rst_rd", 32'(hif.rd_data), 32'(0));
    tick(1);
    reset_l = 1'b1;

    // plain write, no capture
    preload(12'hA5C);
    push_exp(12'hA5C, 12'h3F1, 14, 1, -1);
    start(12'h3F1, 1'b0);
    wait_ack(40);
    tick(2);

    // capture live data, then shift
    live      = 12'h924;
    cells_cap = 1'b1;
    push_exp(12'h924, 12'h5A5, 15, 2, -1);
    start(12'h5A5, 1'b1);
    wait_ack(40);
    cells_cap = 1'b0;
    tick(2);

    // req held through ack, toggled while busy
    push_exp(12'h5A5, 12'h0F0, 14, 1, -1);
    push_exp(12'h0F0, 12'hC33, 14, 1, 2);
    hif.wr_data = 12'h0F0;
    hif.req_cap = 1'b0;
    hif.req     = 1'b1;
    tick(4);
    hif.req = 1'b0;
    tick(2);
    hif.req = 1'b1;
    wait_ack(40);
    hif.wr_data = 12'hC33;
    wait_ack(40);
    hif.req = 1'b0;
    tick(2);

    // test_se override at shift cycle 5
    preload(12'h777);
    start(12'h8E1, 1'b0);
    tick(6);
    test_se = 1'b1;
    test_si = 1'b1;
    #1;
    chk("ovr_se", 32'(se), 32'(1));
    chk("ovr_si1", 32'(si), 32'(1));
    chk("ovr_obsel", 32'(obsel), 32'(func_obsel));
    test_si = 1'b0;
    #1;
    chk("ovr_si0", 32'(si), 32'(0));
    @(negedge clk);
    #1;
    chk("ovr_busy", 32'(hif.busy), 32'(0));
    chk("ovr_ack", 32'(hif.ack), 32'(0));
    chk("ovr_se_hold", 32'(se), 32'(1));
    test_se = 1'b0;
    #1;
    chk("ovr_se_rel", 32'(se), 32'(0));
    tick(3);

    // async reset at shift cycle 7
    preload(12'h333);
    start(12'h456, 1'b0);
    tick(8);
    #2;
    reset_l = 1'b0;
    #1;
    chk("ar_se", 32'(se), 32'(0));
    chk("ar_si", 32'(si), 32'(0));
    chk("ar_busy", 32'(hif.busy), 32'(0));
    chk("ar_ack", 32'(hif.ack), 32'(0));
    chk("ar_rd", 32'(hif.rd_data), 32'(0));
    chk("ar_obsel", 32'(obsel), 32'(func_obsel));
    @(negedge clk);
    reset_l = 1'b1;
    tick(1);

    // normal operation after reset
    preload(12'h1E7);
    push_exp(12'h1E7, 12'h6CA, 14, 1, -1);
    start(12'h6CA, 1'b0);
    wait_ack(40);
    tick(3);

    chk("queue_empty", 32'(q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
